// File: rtl/mux_share_arbiter.sv
// rtl/mux_share_arbiter.sv - round-robin owner of a shared N:1 select mux with settle-then-sample
//
// Purpose:
//   N requesters share one N:1 select mux. A round-robin arbiter picks one
//   requester and drives the mux select lines. It then waits a programmable
//   settle interval so the mux propagation delay has elapsed. After that it
//   samples the fed-back mux output once for the granted requester. The grant
//   is held until that requester drops its request.
//
// Parameters:
//   N      number of requesters / mux inputs (must equal 2**SW)
//   SW     select width
//   SETTLE cycles spent in SETTLE before sampling; 0 is treated as 1
//
// Ports:
//   clk      in   1   system clock, rising edge
//   rst      in   1   asynchronous active-high reset
//   req      in   N   per-requester request, held until release
//   mux_out  in   1   output of the shared mux
//   sel      out  SW  registered mux select
//   grant    out  N   one-hot grant, all zero when idle
//   busy     out  1   high whenever the FSM is not in IDLE
//   done     out  1   one-cycle strobe: data holds a fresh sample
//   data     out  1   last sampled mux_out, held until the next sample

module mux_share_arbiter #(
  parameter int N      = 16,
  parameter int SW     = 4,
  parameter int SETTLE = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          mux_out,
  output logic [SW-1:0] sel,
  output logic [N-1:0]  grant,
  output logic          busy,
  output logic          done,
  output logic          data
);

  // A settle interval of zero would sample in the same cycle the select
  // moves, so it is clamped to one cycle.
  localparam int SETTLE_EFF = (SETTLE < 1) ? 1 : SETTLE;
  localparam int CW         = $clog2(SETTLE_EFF + 1);

  localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE_EFF - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [N-1:0]  ONE_N    = N'(1);
  localparam logic [SW-1:0] ONE_SW   = SW'(1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SETTLE  = 2'd1;
  localparam logic [1:0] S_SAMPLE  = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [SW-1:0] r_ptr;
  logic [SW-1:0] r_sel;
  logic [N-1:0]  r_grant;
  logic          r_busy;
  logic          r_done;
  logic          r_data;

  logic          w_found;
  logic [SW-1:0] w_pick;
  logic [SW-1:0] w_idx;
  logic          w_req_g;
  logic [SW-1:0] w_ptr_next;

  // Round-robin pick. Walk the offsets from the highest down to zero, so
  // the smallest offset from r_ptr that has a request is written last and
  // wins. SW-bit addition wraps modulo N because N == 2**SW.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_ptr;
    w_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      w_idx = r_ptr + SW'(i);
      if (req[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  // While busy, r_sel always names the granted requester.
  assign w_req_g    = req[r_sel];
  assign w_ptr_next = r_sel + ONE_SW;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ptr   <= '0;
      r_sel   <= '0;
      r_grant <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_data  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // r_sel is left alone when there is no request, so the mux
          // input stays put and nothing toggles needlessly.
          if (w_found) begin
            r_sel   <= w_pick;
            r_grant <= ONE_N << w_pick;
            r_cnt   <= CNT_INIT;
            r_busy  <= 1'b1;
            r_state <= S_SETTLE;
          end
        end

        S_SETTLE: begin
          // A withdrawn request aborts before any sample is taken.
          if (!w_req_g) begin
            r_grant <= '0;
            r_ptr   <= w_ptr_next;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_cnt == '0) begin
            r_state <= S_SAMPLE;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end

        S_SAMPLE: begin
          r_data  <= mux_out;
          r_done  <= 1'b1;
          r_state <= S_RELEASE;
        end

        S_RELEASE: begin
          // Grant and select hold until the owner lets go. The pointer then
          // moves past it, so it cannot be re-granted until it re-requests
          // and every other requester has had its turn.
          if (!w_req_g) begin
            r_grant <= '0;
            r_ptr   <= w_ptr_next;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_grant <= '0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign sel   = r_sel;
  assign grant = r_grant;
  assign busy  = r_busy;
  assign done  = r_done;
  assign data  = r_data;

endmodule
